// File: rtl/bcd_timer_pkg.sv
// Shared constants for the BCD stopwatch/countdown controller:
// state encoding, digit limit, count direction and preset clamping.
package bcd_timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Clamp each nibble of a raw preset to a legal BCD digit.
    function automatic logic [7:0] sanitizeBcd(input logic [7:0] raw);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = (raw[7:4] > BCD_MAX) ? BCD_MAX : raw[7:4];
        units = (raw[3:0] > BCD_MAX) ? BCD_MAX : raw[3:0];
        return {tens, units};
    endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// Pushbutton, mode/preset and digit/status bundle between the board
// side (master) and the timer controller (slave).
interface bcd_timer_if;

    logic       iStart;
    logic       iStop;
    logic       iClear;
    logic       iDown;
    logic [7:0] iPreset;
    logic [3:0] oSalida1;
    logic [3:0] oSalida2;
    logic       oRunning;
    logic       oDone;

    modport master (
        output iStart, iStop, iClear, iDown, iPreset,
        input  oSalida1, oSalida2, oRunning, oDone
    );

    modport slave (
        input  iStart, iStop, iClear, iDown, iPreset,
        output oSalida1, oSalida2, oRunning, oDone
    );

endinterface

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD up/down counter with synchronous load and count enable.
// Load takes priority over counting; loaded values are clamped to 0-9.
module bcd_digit_pair
    import bcd_timer_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iLoad,
    input  logic [7:0] iLoadVal,
    input  logic       iEn,
    input  logic       iDown,
    output logic [3:0] oUnits,
    output logic [3:0] oTens,
    output logic       oZero
);

    logic [7:0] loadClamped;

    assign loadClamped = sanitizeBcd(iLoadVal);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oUnits <= 4'd0;
            oTens  <= 4'd0;
        end else if (iLoad) begin
            oTens  <= loadClamped[7:4];
            oUnits <= loadClamped[3:0];
        end else if (iEn) begin
            if (iDown == MODE_DOWN) begin
                if (oUnits == 4'd0) begin
                    oUnits <= BCD_MAX;
                    oTens  <= (oTens == 4'd0) ? BCD_MAX : oTens - 4'd1;
                end else begin
                    oUnits <= oUnits - 4'd1;
                end
            end else begin
                if (oUnits >= BCD_MAX) begin
                    oUnits <= 4'd0;
                    oTens  <= (oTens >= BCD_MAX) ? 4'd0 : oTens + 4'd1;
                end else begin
                    oUnits <= oUnits + 4'd1;
                end
            end
        end
    end

    assign oZero = (oUnits == 4'd0) && (oTens == 4'd0);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Stopwatch/countdown controller: synchronized button edges drive a
// run/pause/done FSM that gates a BCD digit pair through a prescaler.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | cleared/reset, digits hold the reload value
//   ST_RUN   | prescaler running, digits step on every tick
//   ST_PAUSE | prescaler and digits frozen, start resumes
//   ST_DONE  | countdown reached 00, only clear leaves
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
)(
    input  logic       iClk,
    input  logic       iRst_n,
    bcd_timer_if.slave bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // Bit order in the button vectors: {clear, stop, start}.
    logic [2:0]    btnSync1;
    logic [2:0]    btnSync2;
    logic [2:0]    btnSync2D;
    logic [2:0]    btnPulse;
    logic          startPulse;
    logic          stopPulse;
    logic          clearPulse;

    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic          mode;
    logic [PW-1:0] presc;
    logic          tick;
    logic          stepToZero;

    logic [3:0]    units;
    logic [3:0]    tens;
    logic          digitsZero;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            btnSync1  <= 3'b000;
            btnSync2  <= 3'b000;
            btnSync2D <= 3'b000;
        end else begin
            btnSync1  <= {bus.iClear, bus.iStop, bus.iStart};
            btnSync2  <= btnSync1;
            btnSync2D <= btnSync2;
        end
    end

    assign btnPulse   = btnSync2 & ~btnSync2D;
    assign startPulse = btnPulse[0];
    assign stopPulse  = btnPulse[1];
    assign clearPulse = btnPulse[2];

    assign tick       = (state == ST_RUN) && (presc == PRESC_LAST);
    assign stepToZero = (mode == MODE_DOWN) && (tens == 4'd0) && (units == 4'd1);

    // Stop outranks start in every state, so a coincident pair is a no-op
    // outside RUN; finishing a countdown outranks a coincident stop.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (startPulse && !stopPulse) begin
                    stateNext = ((bus.iDown == MODE_DOWN) && digitsZero) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick && stepToZero) begin
                    stateNext = ST_DONE;
                end else if (stopPulse) begin
                    stateNext = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (startPulse && !stopPulse) begin
                    stateNext = ST_RUN;
                end
            end
            default: stateNext = state;
        endcase
        if (clearPulse) begin
            stateNext = ST_IDLE;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= ST_IDLE;
            mode         <= MODE_UP;
            bus.oRunning <= 1'b0;
            bus.oDone    <= 1'b0;
        end else begin
            state        <= stateNext;
            bus.oRunning <= (state == ST_RUN);
            bus.oDone    <= (state == ST_DONE);
            if ((state == ST_IDLE) && startPulse && !stopPulse && !clearPulse) begin
                mode <= bus.iDown;
            end
        end
    end

    // The stop edge itself does not advance the prescaler, so a resume
    // finishes exactly the cycles that were left when it paused.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            presc <= '0;
        end else if (clearPulse) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            if (tick) begin
                presc <= '0;
            end else if (!stopPulse) begin
                presc <= presc + PW'(1);
            end
        end
    end

    bcd_digit_pair uDigits (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iLoad    (clearPulse),
        .iLoadVal ((bus.iDown == MODE_DOWN) ? bus.iPreset : 8'h00),
        .iEn      (tick && !clearPulse),
        .iDown    (mode),
        .oUnits   (units),
        .oTens    (tens),
        .oZero    (digitsZero)
    );

    assign bus.oSalida1 = units;
    assign bus.oSalida2 = tens;

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Stopwatch/countdown controller that sequences a two-digit BCD counter (tens/units, 00–99) from three pushbutton inputs. Start/stop/clear are synchronized and edge-detected. A run/pause/done FSM and a prescaler gate the count to one step per `TICK_DIV` clocks. It sits between the board pushbuttons and the 7-segment digit decoders, replacing the free-running digit counter with a controlled one.

## Interface
- `TICK_DIV`, default 50_000_000: clocks per count step (1 Hz at 50 MHz). Must be ≥ 2.
- `iClk` in 1: single clock; every register is in this domain.
- `iRst_n` in 1: asynchronous, active-low reset.
- `iStart` in 1: start/resume button, level, asynchronous to `iClk`.
- `iStop` in 1: pause button, level, asynchronous.
- `iClear` in 1: clear/reload button, level, asynchronous.
- `iDown` in 1: mode select, 0 = count up, 1 = count down. Latched only on IDLE→RUN.
- `iPreset` in 8: BCD preset for down mode; [7:4] = tens, [3:0] = units.
- `oSalida1` out 4: units digit, BCD.
- `oSalida2` out 4: tens digit, BCD.
- `oRunning` out 1: high in RUN.
- `oDone` out 1: high in DONE.

## Operation
- Button path:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector: `pulse = sync2 & ~sync2_d`.
  - One press produces one single-cycle pulse.
- FSM states: IDLE, RUN, PAUSE, DONE. Priority is clear > stop > start.
  - Clear, from any state → IDLE. Prescaler := 0. Digits := 00 if `iDown`=0, else the sanitized preset.
  - Start in IDLE → RUN; latches `iDown` into the mode register. In down mode with digits = 00, start → DONE instead.
  - Start in PAUSE → RUN, mode unchanged.
  - Stop in RUN → PAUSE.
  - All other button pulses are ignored, including start in DONE, stop in IDLE/PAUSE/DONE, and start in RUN.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 only in RUN; frozen in PAUSE; cleared on clear.
  - `tick` is asserted in the RUN cycle where prescaler = `TICK_DIV`-1.
- Count on `tick`:
  - Up: units+1; at units 9 → units 0 and tens+1; 99 → 00 wraps; stays in RUN, `oDone` stays 0.
  - Down: units-1; at units 0 → units 9 and tens-1. When the result is 00, the same edge enters DONE.
- DONE holds 00 until clear.
- Preset sanitization: any preset nibble > 9 loads as 9 (e.g. 8'hA5 → 95).
- Simultaneous events:
  - A stop pulse in a `tick` cycle: the count step is applied, then PAUSE.
  - A clear pulse in a `tick` cycle: clear wins and the step is discarded.
- Reset (asynchronous, any time, including mid-RUN): state IDLE, digits 00, prescaler 0, synchronizers 0, mode 0, `oRunning`=0, `oDone`=0.
- Digits are never outside 0–9.

## Timing
- Button latency: the button is first sampled high at edge k. The pulse is valid after edge k+1. The state changes at edge k+2.
- `oRunning` and `oDone` are registered state decodes, valid the cycle after the state register updates.
- Count step latency:
  - Digits update on the edge where `tick` is high.
  - The first step after IDLE→RUN occurs `TICK_DIV` cycles after entering RUN.
  - After PAUSE→RUN the next step occurs after the remaining prescaler cycles.
- Digit outputs are registered with no combinational path from inputs.
- Buttons held high produce no repeat pulses.

## Structure
- Shared package `bcd_timer_pkg`:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - `BCD_MAX` = 4'd9.
  - Mode constants `MODE_UP` / `MODE_DOWN`.
- Sub-module `bcd_digit_pair`:
  - Two-digit BCD up/down counter with synchronous load (8-bit), enable, and direction.
  - Outputs both digits plus a `zero` flag.
  - The top level owns the synchronizers, FSM and prescaler.

## Test plan
All scenarios use `TICK_DIV`=4.
- Async reset mid-RUN at count 37: drop `iRst_n` between clock edges → digits 00, `oRunning` 0, `oDone` 0 immediately, with no clock edge needed.
- Up count: clear, start (`iDown`=0) → digits step every 4 cycles 00,01…09,10…99,00 wrap. `oDone` stays 0 and `oRunning` stays 1 throughout.
- Down count: `iPreset`=8'h12, `iDown`=1, clear, start → 12,11,10,09…01,00. On reaching 00: `oDone`=1, `oRunning`=0, hold 00. A start pulse then has no effect; clear → IDLE with 12 reloaded.
- Pause/resume: stop when prescaler = 2 at count 05 → 05 holds for 50 cycles. Start → 06 appears exactly 2 cycles after entering RUN.
- Priority: start and clear rising in the same cycle while in RUN at 44 → IDLE, 00, `oRunning` 0. Stop coinciding with `tick` at 20 → 21 then PAUSE.
- Sanitization/edge cases:
  - `iPreset`=8'hA5 down mode, clear → 95.
  - `iPreset`=8'h00, start → DONE at the next edge.
  - Button held 100 cycles → exactly one transition.
